// File: rtl/gift_pipe_pkg.sv
// Shared constants for the pipelined GIFT datapath tail.
// No logic; sizing only.
// Consumers derive their default parameters from these values.
package gift_pipe_pkg;

    localparam int GIFT_BLOCK_W       = 128;
    localparam int GIFT_TAG_W         = 4;
    localparam int GIFT_OUT_DEPTH     = 4;
    localparam int GIFT_OUT_AF_MARGIN = 1;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gift_pipe_out_mem.sv
// Register array holding buffered cipher blocks and their tags.
// Write lands on the clock edge; read is combinational at rd_addr.
// No flow control here; the owning FIFO decides when wr_en fires.
module gift_pipe_out_mem
    import gift_pipe_pkg::*;
#(
    parameter int  DATA_W = GIFT_BLOCK_W,
    parameter int  TAG_W  = GIFT_TAG_W,
    parameter int  DEPTH  = GIFT_OUT_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_dat,
    output logic [TAG_W-1:0]  rd_tag
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];

    // Storage is not reset: validity is tracked by the FIFO's count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_addr] <= wr_dat;
            tag_q[wr_addr]  <= wr_tag;
        end
    end

    // DEPTH is a power of two, so every rd_addr value selects a real entry.
    assign rd_dat = data_q[rd_addr];
    assign rd_tag = tag_q[rd_addr];

endmodule

// File: rtl/gift_pipe_out_fifo.sv
// Output buffer for finished GIFT blocks with first-word fall-through to the consumer.
// Latency: a word written at edge k is visible on outData/outValid from cycle k+1.
// Backpressure: outFull/outAlmostFull stall issue upstream; writes while full without a pop are dropped and flagged.
module gift_pipe_out_fifo
    import gift_pipe_pkg::*;
#(
    parameter int DATA_W    = GIFT_BLOCK_W,
    parameter int TAG_W     = GIFT_TAG_W,
    parameter int DEPTH     = GIFT_OUT_DEPTH,
    parameter int AF_MARGIN = GIFT_OUT_AF_MARGIN,
    parameter bit ZERO_IDLE = 1'b1,
    localparam int CNT_W    = occ_w(DEPTH)
) (
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              inWr,
    input  logic [DATA_W-1:0] inData,
    input  logic [TAG_W-1:0]  inTag,
    input  logic              inReady,
    input  logic              inClrErr,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    output logic [TAG_W-1:0]  outTag,
    output logic [CNT_W-1:0]  outCount,
    output logic              outFull,
    output logic              outAlmostFull,
    output logic              outOverflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] hold_dat_q, hold_dat_d;
    logic [TAG_W-1:0]  hold_tag_q, hold_tag_d;

    logic              not_empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] head_dat;
    logic [TAG_W-1:0]  head_tag;

    gift_pipe_out_mem #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (inClk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_dat  (inData),
        .wr_tag  (inTag),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head_dat),
        .rd_tag  (head_tag)
    );

    // Handshake decode; a write into a full buffer is still accepted when the head pops in the same cycle.
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == CNT_W'(DEPTH));
        pop       = not_empty && inReady;
        push      = inWr && (!full || pop);
        drop      = inWr && full && !pop;
    end

    // Next-state for pointers, occupancy, sticky overflow and the last-popped hold register.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        hold_dat_d = hold_dat_q;
        hold_tag_d = hold_tag_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            hold_dat_d = head_dat;
            hold_tag_d = head_tag;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh drop outranks a clear arriving in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (inClrErr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; reset discards all buffered content.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            hold_dat_q <= '0;
            hold_tag_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            hold_dat_q <= hold_dat_d;
            hold_tag_q <= hold_tag_d;
        end
    end

    // Outputs come straight from registered state, so reset clears them immediately.
    always_comb begin
        outValid      = not_empty;
        outCount      = count_q;
        outFull       = full;
        outAlmostFull = (count_q >= CNT_W'(DEPTH - AF_MARGIN));
        outOverflow   = ovf_q;
        if (not_empty) begin
            outData = head_dat;
            outTag  = head_tag;
        end else if (ZERO_IDLE) begin
            outData = '0;
            outTag  = '0;
        end else begin
            outData = hold_dat_q;
            outTag  = hold_tag_q;
        end
    end

endmodule

// File: tb/tb_gift_pipe_out_fifo.sv
// Bench for gift_pipe_out_fifo: directed scenarios plus random traffic against a queue model.
// Two instances share stimulus: one zeroes its idle output, the other holds the last popped word.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_gift_pipe_out_fifo;

    localparam int DEPTH = 4;
    localparam int AF    = 1;

    typedef struct packed {
        logic [3:0]   tag;
        logic [127:0] dat;
    } ent_t;

    logic         clk = 1'b0;
    logic         in_rst_n;
    logic         in_wr;
    logic [127:0] in_dat;
    logic [3:0]   in_tag;
    logic         in_rdy;
    logic         in_clr;

    logic         z_vld, z_full, z_af, z_ovf;
    logic [127:0] z_dat;
    logic [3:0]   z_tag;
    logic [2:0]   z_cnt;
    logic         h_vld, h_full, h_af, h_ovf;
    logic [127:0] h_dat;
    logic [3:0]   h_tag;
    logic [2:0]   h_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t         model_q[$];
    logic         m_ovf;
    logic [127:0] m_last_dat;
    logic [3:0]   m_last_tag;

    always #5 clk = ~clk;

    gift_pipe_out_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF), .ZERO_IDLE(1'b1)) dut_z (
        .inClk(clk), .inRstN(in_rst_n), .inWr(in_wr), .inData(in_dat), .inTag(in_tag),
        .inReady(in_rdy), .inClrErr(in_clr), .outValid(z_vld), .outData(z_dat), .outTag(z_tag),
        .outCount(z_cnt), .outFull(z_full), .outAlmostFull(z_af), .outOverflow(z_ovf)
    );

    gift_pipe_out_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF), .ZERO_IDLE(1'b0)) dut_h (
        .inClk(clk), .inRstN(in_rst_n), .inWr(in_wr), .inData(in_dat), .inTag(in_tag),
        .inReady(in_rdy), .inClrErr(in_clr), .outValid(h_vld), .outData(h_dat), .outTag(h_tag),
        .outCount(h_cnt), .outFull(h_full), .outAlmostFull(h_af), .outOverflow(h_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare both instances against the queue model.
    task automatic check_state();
        int           n;
        logic [127:0] e_dat_z, e_dat_h;
        logic [3:0]   e_tag_z, e_tag_h;
        n = model_q.size();
        if (n != 0) begin
            e_dat_z = model_q[0].dat; e_tag_z = model_q[0].tag;
            e_dat_h = model_q[0].dat; e_tag_h = model_q[0].tag;
        end else begin
            e_dat_z = '0;         e_tag_z = '0;
            e_dat_h = m_last_dat; e_tag_h = m_last_tag;
        end
        chk("valid_z", 128'(z_vld), 128'(n != 0));
        chk("valid_h", 128'(h_vld), 128'(n != 0));
        chk("count_z", 128'(z_cnt), 128'(n));
        chk("count_h", 128'(h_cnt), 128'(n));
        chk("full",    128'(z_full), 128'(n == DEPTH));
        chk("afull",   128'(z_af),   128'(n >= DEPTH - AF));
        chk("ovf_z",   128'(z_ovf),  128'(m_ovf));
        chk("ovf_h",   128'(h_ovf),  128'(m_ovf));
        chk("data_z",  z_dat, e_dat_z);
        chk("tag_z",   128'(z_tag), 128'(e_tag_z));
        chk("data_h",  h_dat, e_dat_h);
        chk("tag_h",   128'(h_tag), 128'(e_tag_h));
    endtask

    // One clock of stimulus: check current outputs, drive inputs, advance model at the edge.
    task automatic cycle(input logic w, input logic [127:0] d, input logic [3:0] t,
                         input logic r, input logic c);
        bit m_full, m_pop, m_push;
        check_state();
        in_wr = w; in_dat = d; in_tag = t; in_rdy = r; in_clr = c;
        m_full = (model_q.size() == DEPTH);
        m_pop  = (model_q.size() != 0) && r;
        m_push = w && (!m_full || m_pop);
        @(posedge clk);
        if (m_pop) begin
            m_last_dat = model_q[0].dat;
            m_last_tag = model_q[0].tag;
            void'(model_q.pop_front());
        end
        if (m_push) model_q.push_back(ent_t'({t, d}));
        if (w && m_full && !m_pop) m_ovf = 1'b1;
        else if (c)                m_ovf = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        in_wr = 1'b0; in_rdy = 1'b0; in_clr = 1'b0;
        in_rst_n = 1'b0;
        #1;
        model_q.delete();
        m_ovf = 1'b0; m_last_dat = '0; m_last_tag = '0;
        chk("rst_valid", 128'(z_vld), 128'(0));
        chk("rst_count", 128'(z_cnt), 128'(0));
        chk("rst_data_z", z_dat, 128'(0));
        chk("rst_data_h", h_dat, 128'(0));
        @(negedge clk);
        check_state();
        in_rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] pat;
        in_rst_n = 1'b0; in_wr = 1'b0; in_dat = '0; in_tag = '0; in_rdy = 1'b0; in_clr = 1'b0;
        model_q.delete();
        m_ovf = 1'b0; m_last_dat = '0; m_last_tag = '0;
        @(negedge clk);
        do_reset();

        // Three writes, no consumer: almost full, head is the first word.
        pat = {32{4'hA}}; cycle(1, pat, 4'd1, 0, 0);
        pat = {32{4'hB}}; cycle(1, pat, 4'd2, 0, 0);
        pat = {32{4'hC}}; cycle(1, pat, 4'd3, 0, 0);
        chk("t1_af",   128'(z_af),   128'(1));
        chk("t1_full", 128'(z_full), 128'(0));
        chk("t1_head", z_dat, {32{4'hA}});

        // Fill, then a dropped write; set and clear together keeps the flag set.
        pat = {32{4'hD}}; cycle(1, pat, 4'd4, 0, 0);
        pat = {32{4'hE}}; cycle(1, pat, 4'd5, 0, 0);
        chk("t2_ovf", 128'(z_ovf), 128'(1));
        pat = {32{4'hF}}; cycle(1, pat, 4'd6, 0, 1);
        chk("t2_ovf_setwins", 128'(z_ovf), 128'(1));
        cycle(0, '0, 4'd0, 0, 1);
        chk("t2_ovf_clr", 128'(z_ovf), 128'(0));

        // Full with simultaneous write and pop for eight cycles; pointers wrap twice.
        for (int i = 0; i < 8; i++) begin
            cycle(1, rnd128(), 4'(i + 7), 1, 0);
        end

        // Drain to empty: zero-idle output is 0, hold instance shows the last popped word.
        for (int i = 0; i < 4; i++) cycle(0, '0, 4'd0, 1, 0);
        chk("t4_idle_z", z_dat, 128'(0));
        // Empty with inReady asserted is ignored.
        cycle(0, '0, 4'd0, 1, 0);

        // Empty with write and ready on the same edge: word kept.
        pat = rnd128(); cycle(1, pat, 4'd9, 1, 0);
        chk("t5_head", z_dat, pat);

        // Reset mid-burst with two entries.
        cycle(1, rnd128(), 4'd10, 0, 0);
        chk("t6_cnt2", 128'(z_cnt), 128'(2));
        do_reset();
        pat = rnd128(); cycle(1, pat, 4'd11, 0, 0);
        chk("t6_first", z_dat, pat);
        cycle(0, '0, 4'd0, 1, 0);

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle(($urandom % 10) < 6, rnd128(), 4'($urandom), ($urandom % 10) < 5,
                  ($urandom % 8) == 0);
        end
        check_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
